ingress_parser: RTL
===================

Name: ingress_parser

Overview:
- Sits directly downstream of the packet generator; consumes its 32-bit word stream, one packet at a time.
- Parses header words: length, destination MAC, timestamp, source MAC.
- Packs every 8 words (one 32-byte block) into a packet-buffer write; emits one descriptor per accepted packet toward the VOQ stage.
- Tracks buffer occupancy and drops packets that are malformed, addressed to an unknown MAC, or cannot fit.

Parameters:
- BUF_BLOCKS, 1024, packet buffer capacity in 32-byte blocks (power of 2).
- BLK_ADDR_W, $clog2(BUF_BLOCKS), block address width.
- MAX_BLOCKS, 63, largest legal packet length in blocks.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data carries a word this cycle
- in_sop  in  1  first word of a packet; qualified by in_valid
- in_data  in  32  packet word
- blk_wr_en  out  1  block write strobe
- blk_wr_addr  out  BLK_ADDR_W  block address
- blk_wr_data  out  256  block data; word 0 in bits [255:224]
- desc_valid  out  1  one-cycle descriptor pulse; no backpressure
- desc_dst_port  out  2  decoded destination port
- desc_src_port  out  2  decoded source port
- desc_start_addr  out  BLK_ADDR_W  first block address
- desc_len  out  6  length in blocks
- desc_time  out  22  start timestamp
- rel_en  in  1  downstream frees blocks
- rel_len  in  6  number of blocks freed
- occupancy  out  BLK_ADDR_W+1  reserved blocks
- drop_cnt  out  16  dropped packets; saturating

Behaviour:
- Reset: all outputs 0; FSM to IDLE; write pointer, occupancy and drop_cnt cleared.
- Reset mid-packet abandons the packet; nothing is written and no descriptor is emitted.
- Packet format (words accepted on in_valid):
  - w0 = {len_bytes[15:0], dmac[47:32]}
  - w1 = dmac[31:0]
  - w2 = {10'b0, time[21:0]}
  - w3 = 0
  - w4 = {16'b0, smac[47:32]}
  - w5 = smac[31:0]
  - w6 onward = payload
  - Total words = 8 * len_blk, where len_blk = len_bytes[10:5].
- FSM states:
  - IDLE: in_valid & in_sop -> HDR. in_valid without in_sop is ignored.
  - HDR: covers w0..w5. Admission decision on w1.
    - Drop if any of: len_bytes[4:0] != 0; len_blk == 0; len_bytes > MAX_BLOCKS*32; dmac or smac unmapped; len_blk > BUF_BLOCKS - occupancy.
    - Drop -> DROP and increment drop_cnt. Accept -> reserve len_blk blocks (occupancy += len_blk).
  - Accepted packet, after w5: -> BODY.
  - BODY: runs until the word count reaches 8*len_blk, then -> IDLE.
  - DROP: consumes words until the same count is reached, then -> IDLE.
- Block assembly:
  - 3-bit word index fills a 256-bit shift register.
  - On the 8th word, blk_wr_en pulses the next cycle with blk_wr_addr = wr_ptr; wr_ptr then increments.
  - wr_ptr wraps modulo BUF_BLOCKS.
- Descriptor: desc_valid pulses in the same cycle as the last block's blk_wr_en. Fields are captured during the header.
- Occupancy update:
  - occupancy <= occupancy + reserve - release, where reserve and release may occur in the same cycle.
  - Release is clamped so occupancy never goes below 0.
- in_sop arriving while not in IDLE is an abort:
  - wr_ptr rewinds to the packet start.
  - The reservation is returned.
  - drop_cnt increments.
  - The new word is processed as the w0 of a new packet.
- Gaps (in_valid low) are allowed anywhere in a packet; state holds.

Decomposition:
- Shared package ingress_pkg: state enum, header word offsets, BLOCK_WORDS = 8, MAC_BASE constant, and the MAC table. The table is the same one the port_to_mac encoder uses.
- Sub-module mac_to_port: combinational reverse lookup {mac[47:0]} -> {hit, port[1:0]}, instantiated once each for dmac and smac.

Test Plan:
- Accepted 2-block packet (len_bytes = 64, dmac maps to port 2, smac to port 1, time = 22'h1234), empty buffer -> blk_wr_en at addr 0 and 1; desc_valid with dst = 2, src = 1, start = 0, len = 2, time = 0x1234; occupancy = 2.
- len_bytes = 40 (not block-aligned) -> 0 writes, drop_cnt = 1, FSM returns to IDLE after exactly 8 words. Repeat with an unmapped dmac -> drop_cnt = 2.
- Fill to occupancy = 1020, then send a 5-block packet -> dropped. Then rel_en with rel_len = 4 in the same cycle as a 3-block reservation -> occupancy = 1019.
- With wr_ptr = 1022, send a 3-block packet -> writes at 1022, 1023, 0; desc_start_addr = 1022.
- in_sop on word 11 of a 3-block packet -> wr_ptr back to start, occupancy restored, drop_cnt + 1; the following 1-block packet is written at the original start address.
- Assert reset mid-BODY, then send a 1-block packet -> all outputs 0 during reset; the packet is written at addr 0 and occupancy = 1.

Source files
------------

// File: rtl/ingress_pkg.sv
// ingress_pkg: parser state, header word offsets and the MAC-to-port table
// shared by the ingress parser and the port_to_mac encoder.
package ingress_pkg;

    typedef enum logic [1:0] {IDLE, HDR, BODY, DROP} state_t;

    localparam int WCNT_W      = 9;
    localparam int BLOCK_WORDS = 8;
    localparam int NUM_PORTS   = 4;

    localparam logic [WCNT_W-1:0] W_DMAC_LO = 9'd1;
    localparam logic [WCNT_W-1:0] W_TIME    = 9'd2;
    localparam logic [WCNT_W-1:0] W_SMAC_HI = 9'd4;
    localparam logic [WCNT_W-1:0] W_SMAC_LO = 9'd5;

    localparam logic [47:0] MAC_BASE = 48'h02AA_BB00_0000;

    // Port p owns MAC_BASE + p.
    function automatic logic [47:0] port_to_mac(input logic [1:0] port);
        return MAC_BASE | {46'b0, port};
    endfunction

endpackage

// File: rtl/ingress_parser_if.sv
// ingress_parser_if: word stream and release input, block-write and
// descriptor outputs of the ingress parser.
interface ingress_parser_if #(parameter int BLK_ADDR_W = 10) ();

    logic                  in_valid;
    logic                  in_sop;
    logic [31:0]           in_data;
    logic                  blk_wr_en;
    logic [BLK_ADDR_W-1:0] blk_wr_addr;
    logic [255:0]          blk_wr_data;
    logic                  desc_valid;
    logic [1:0]            desc_dst_port;
    logic [1:0]            desc_src_port;
    logic [BLK_ADDR_W-1:0] desc_start_addr;
    logic [5:0]            desc_len;
    logic [21:0]           desc_time;
    logic                  rel_en;
    logic [5:0]            rel_len;

    modport master (
        output in_valid, in_sop, in_data, rel_en, rel_len,
        input  blk_wr_en, blk_wr_addr, blk_wr_data, desc_valid, desc_dst_port,
               desc_src_port, desc_start_addr, desc_len, desc_time
    );

    modport slave (
        input  in_valid, in_sop, in_data, rel_en, rel_len,
        output blk_wr_en, blk_wr_addr, blk_wr_data, desc_valid, desc_dst_port,
               desc_src_port, desc_start_addr, desc_len, desc_time
    );

endinterface

// File: rtl/mac_to_port.sv
// mac_to_port: reverse lookup of a 48-bit MAC in the shared port table.
module mac_to_port
    import ingress_pkg::*;
(
    input  logic [47:0] mac,
    output logic        hit,
    output logic [1:0]  port
);

    always_comb begin
        hit  = 1'b0;
        port = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mac == port_to_mac(2'(i))) begin
                hit  = 1'b1;
                port = 2'(i);
            end
        end
    end

endmodule

// File: rtl/ingress_parser.sv
// ingress_parser: parses packet headers, admits or drops packets, packs
// words into 32-byte block writes and emits one descriptor per packet.
module ingress_parser
    import ingress_pkg::*;
#(
    parameter int BUF_BLOCKS = 1024,
    parameter int BLK_ADDR_W = $clog2(BUF_BLOCKS),
    parameter int MAX_BLOCKS = 63
) (
    input  logic              clk,
    input  logic              reset,
    ingress_parser_if.slave   bus,
    output logic [BLK_ADDR_W:0] occupancy,
    output logic [15:0]       drop_cnt
);

    localparam int OCC_W = BLK_ADDR_W + 1;

    state_t                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [15:0]           len_bytes_q, len_bytes_d;
    logic [15:0]           dmac_hi_q, dmac_hi_d;
    logic [15:0]           smac_hi_q, smac_hi_d;
    logic [21:0]           time_q, time_d;
    logic [1:0]            dst_q, dst_d;
    logic [1:0]            src_q, src_d;
    logic                  res_q, res_d;
    logic [BLK_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BLK_ADDR_W-1:0] start_q, start_d;
    logic [BLK_ADDR_W-1:0] addr_q, addr_d;
    logic [255:0]          shreg_q, shreg_d;
    logic                  wr_en_q, wr_en_d;
    logic                  desc_q, desc_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [15:0]           drop_q, drop_d;

    logic [OCC_W-1:0]      occ_mid, free_blk;
    logic [5:0]            len_blk, reserve, unres, rel;
    logic [WCNT_W-1:0]     total;
    logic                  drop_inc, reject, dhit, shit;
    logic [1:0]            dport, sport;

    mac_to_port u_dmac (.mac({dmac_hi_q, bus.in_data}), .hit(dhit), .port(dport));
    mac_to_port u_smac (.mac({smac_hi_q, bus.in_data}), .hit(shit), .port(sport));

    assign len_blk  = len_bytes_q[10:5];
    assign total    = {len_blk, 3'b0};
    assign free_blk = OCC_W'(BUF_BLOCKS) - occ_q;
    assign reject   = len_bytes_q[4:0] != '0 || len_blk == '0 || !dhit ||
                      len_bytes_q > 16'(MAX_BLOCKS * 32) || OCC_W'(len_blk) > free_blk;
    assign rel      = bus.rel_en ? bus.rel_len : '0;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        len_bytes_d = len_bytes_q;
        dmac_hi_d   = dmac_hi_q;
        smac_hi_d   = smac_hi_q;
        time_d      = time_q;
        dst_d       = dst_q;
        src_d       = src_q;
        res_d       = res_q;
        wr_ptr_d    = wr_ptr_q;
        start_d     = start_q;
        addr_d      = addr_q;
        shreg_d     = shreg_q;
        wr_en_d     = 1'b0;
        desc_d      = 1'b0;
        reserve     = '0;
        unres       = '0;
        drop_inc    = 1'b0;
        if (bus.in_valid && bus.in_sop) begin
            // A start of packet outside IDLE aborts the packet in flight.
            if (state_q != IDLE) begin
                wr_ptr_d = start_q;
                unres    = res_q ? len_blk : '0;
                drop_inc = 1'b1;
            end
            start_d     = wr_ptr_d;
            state_d     = HDR;
            wcnt_d      = WCNT_W'(1);
            len_bytes_d = bus.in_data[31:16];
            dmac_hi_d   = bus.in_data[15:0];
            res_d       = 1'b0;
            shreg_d     = {shreg_q[223:0], bus.in_data};
        end else if (bus.in_valid && state_q != IDLE) begin
            wcnt_d  = wcnt_q + 1'b1;
            shreg_d = {shreg_q[223:0], bus.in_data};
            if (state_q == HDR && wcnt_q == W_DMAC_LO) begin
                dst_d    = dport;
                state_d  = reject ? DROP : HDR;
                drop_inc = reject;
                reserve  = reject ? '0 : len_blk;
                res_d    = !reject;
            end
            if (state_q == HDR && wcnt_q == W_TIME) time_d = bus.in_data[21:0];
            if (state_q == HDR && wcnt_q == W_SMAC_HI) smac_hi_d = bus.in_data[15:0];
            // Source MAC is only known at w5, so its miss returns the reservation.
            if (state_q == HDR && wcnt_q == W_SMAC_LO) begin
                src_d    = sport;
                state_d  = shit ? BODY : DROP;
                drop_inc = !shit;
                unres    = shit ? '0 : len_blk;
                res_d    = shit;
            end
            if (state_q == BODY && wcnt_q[2:0] == 3'(BLOCK_WORDS - 1)) begin
                wr_en_d  = 1'b1;
                addr_d   = wr_ptr_q;
                wr_ptr_d = wr_ptr_q + 1'b1;
                desc_d   = wcnt_d >= total;
            end
            if ((state_d == BODY || state_d == DROP) && wcnt_d >= total) state_d = IDLE;
        end
        occ_mid = occ_q + OCC_W'(reserve) - OCC_W'(unres);
        occ_d   = occ_mid > OCC_W'(rel) ? occ_mid - OCC_W'(rel) : '0;
        drop_d  = drop_q + 16'(drop_inc && drop_q != 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            len_bytes_q <= '0;
            dmac_hi_q   <= '0;
            smac_hi_q   <= '0;
            time_q      <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            res_q       <= 1'b0;
            wr_ptr_q    <= '0;
            start_q     <= '0;
            addr_q      <= '0;
            shreg_q     <= '0;
            wr_en_q     <= 1'b0;
            desc_q      <= 1'b0;
            occ_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            len_bytes_q <= len_bytes_d;
            dmac_hi_q   <= dmac_hi_d;
            smac_hi_q   <= smac_hi_d;
            time_q      <= time_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            res_q       <= res_d;
            wr_ptr_q    <= wr_ptr_d;
            start_q     <= start_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            wr_en_q     <= wr_en_d;
            desc_q      <= desc_d;
            occ_q       <= occ_d;
            drop_q      <= drop_d;
        end
    end

    // The shift register already holds the completed block while the strobe is high.
    assign bus.blk_wr_en       = wr_en_q;
    assign bus.blk_wr_addr     = addr_q;
    assign bus.blk_wr_data     = shreg_q;
    assign bus.desc_valid      = desc_q;
    assign bus.desc_dst_port   = dst_q;
    assign bus.desc_src_port   = src_q;
    assign bus.desc_start_addr = start_q;
    assign bus.desc_len        = len_blk;
    assign bus.desc_time       = time_q;
    assign occupancy           = occ_q;
    assign drop_cnt            = drop_q;

endmodule
